// File: rtl/pico_bus_pkg.sv
// ============================================================================
// Module      : pico_bus_pkg
// Description : Shared definitions for the pico bus router: register map
//               addresses, CTRL/STATUS field positions and the WMARK reset
//               default.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pico_bus_pkg;

  // Register map (8-bit address space).
  localparam logic [7:0] c_ADDR_CTRL  = 8'h00;
  localparam logic [7:0] c_ADDR_STAT  = 8'h01;
  localparam logic [7:0] c_ADDR_FIFO  = 8'h02;
  localparam logic [7:0] c_ADDR_WMARK = 8'h03;
  localparam logic [7:0] c_ADDR_SIMD  = 8'h04;

  // CTRL fields.
  localparam int c_CTRL_W       = 4;
  localparam int c_CTRL_CAP_EN  = 0;
  localparam int c_CTRL_SEL_LSB = 1;  // two bits wide
  localparam int c_CTRL_LCD_SRC = 3;

  // STATUS fields.
  localparam int c_STAT_EMPTY   = 0;
  localparam int c_STAT_FULL    = 1;
  localparam int c_STAT_OVF     = 2;
  localparam int c_STAT_UDF     = 3;
  localparam int c_STAT_LVL_LSB = 4;  // four bits wide, saturating

  // Watermark comes out of reset at half the FIFO depth.
  function automatic logic [7:0] wmark_default(input int depth);
    return 8'(depth / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. A pop on an empty
//               FIFO is ignored; a push while full is accepted only when a
//               pop happens in the same cycle.
// Ports       : clk, rst (async, active-low)
//               push, wr_data        - write side
//               pop, rd_data         - read side (rd_data shows the head)
//               full, empty, level   - status, level counts 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_level;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty   = (r_level == '0);
  assign full    = (r_level == (c_AW+1)'(DEPTH));
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // that coincides with a pop.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly c_AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + (c_AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - (c_AW+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pico_bus_router.sv
// ============================================================================
// Module      : pico_bus_router
// Description : Bridges an asynchronous pico strobe bus (CS/WR/RD/CD) to a
//               small register file, a camera capture FIFO, an LCD stream
//               and a SIMD data port.
// Ports       : clk, rst (async assert, active-low, release synchronous)
//               CS, WR, RD, CD, pico_data_in       - pico bus inputs
//               pico_data_out, pico_data_oe        - read data / pad enable
//               cam_data, cam_valid                - packed camera channels
//               LCD_data, LCD_valid                - routed LCD stream
//               simd_in, simd_data                 - SIMD result / write value
//               irq                                - watermark or sticky error
// Config      : PICO_BUS_AUTOINC_EN - when defined, the address register
//               increments after every data-cycle access except FIFO_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pico_bus_router
  import pico_bus_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_CAM       = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CS,
  input  logic                    WR,
  input  logic                    RD,
  input  logic                    CD,
  input  logic [DATA_W-1:0]       pico_data_in,
  output logic [DATA_W-1:0]       pico_data_out,
  output logic                    pico_data_oe,
  input  logic [N_CAM*DATA_W-1:0] cam_data,
  input  logic [N_CAM-1:0]        cam_valid,
  output logic [DATA_W-1:0]       LCD_data,
  output logic                    LCD_valid,
  input  logic [DATA_W-1:0]       simd_in,
  output logic [DATA_W-1:0]       simd_data,
  output logic                    irq
);

  localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

`ifdef PICO_BUS_AUTOINC_EN
  localparam bit c_AUTOINC = 1'b1;
`else
  localparam bit c_AUTOINC = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Strobe synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_cs_sync, r_wr_sync, r_rd_sync, r_cd_sync;
  logic                   r_wr_prev, r_rd_prev;
  logic                   w_cs, w_wr, w_rd, w_cd;
  logic                   w_wr_rise, w_rd_rise, w_rd_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_sync <= '0;
      r_wr_sync <= '0;
      r_rd_sync <= '0;
      r_cd_sync <= '0;
      r_wr_prev <= 1'b0;
      r_rd_prev <= 1'b0;
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], WR};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], RD};
      r_cd_sync <= {r_cd_sync[SYNC_STAGES-2:0], CD};
      r_wr_prev <= w_wr;
      r_rd_prev <= w_rd;
    end
  end

  assign w_cs = r_cs_sync[SYNC_STAGES-1];
  assign w_wr = r_wr_sync[SYNC_STAGES-1];
  assign w_rd = r_rd_sync[SYNC_STAGES-1];
  assign w_cd = r_cd_sync[SYNC_STAGES-1];

  // The edge history clears in reset, so a strobe still high at release is
  // seen as a fresh rising edge.
  assign w_wr_rise = w_wr && !r_wr_prev && w_cs;
  assign w_rd_rise = w_rd && !r_rd_prev && w_cs;
  assign w_rd_fall = !w_rd && r_rd_prev;

  logic w_addr_wr, w_data_wr, w_data_rd;
  assign w_addr_wr = w_wr_rise && w_cd;
  assign w_data_wr = w_wr_rise && !w_cd;
  assign w_data_rd = w_rd_rise && !w_cd;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [7:0]          r_addr;
  logic [c_CTRL_W-1:0] r_ctrl;
  logic [7:0]          r_wmark;
  logic                r_ovf, r_udf;
  logic                r_pop_pend;
  logic [DATA_W-1:0]   r_simd_data;
  logic [DATA_W-1:0]   r_data_out;
  logic [DATA_W-1:0]   r_lcd_data;
  logic                r_lcd_valid;

  // --------------------------------------------------------------------------
  // Camera channel select (out-of-range selections fall back to channel 0)
  // --------------------------------------------------------------------------
  logic [1:0]        w_sel;
  logic [DATA_W-1:0] w_cam_pix;
  logic              w_cam_vld;

  always_comb begin
    w_sel = r_ctrl[c_CTRL_SEL_LSB +: 2];
    if (int'(w_sel) >= N_CAM) begin
      w_sel = 2'd0;
    end
    w_cam_pix = '0;
    w_cam_vld = 1'b0;
    for (int i = 0; i < N_CAM; i++) begin
      if (int'(w_sel) == i) begin
        w_cam_pix = cam_data[i*DATA_W +: DATA_W];
        w_cam_vld = cam_valid[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture FIFO
  // --------------------------------------------------------------------------
  logic               w_push, w_pop_req;
  logic [DATA_W-1:0]  w_fifo_head;
  logic               w_full, w_empty;
  logic [c_LVL_W-1:0] w_level;

  assign w_push    = r_ctrl[c_CTRL_CAP_EN] && w_cam_vld;
  // The pop is deferred to the RD falling edge so the head stays on the bus
  // for the whole read strobe.
  assign w_pop_req = w_rd_fall && r_pop_pend;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_cam_pix),
    .pop     (w_pop_req),
    .rd_data (w_fifo_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [3:0]        w_lvl_sat;
  logic [7:0]        w_status;
  logic [DATA_W-1:0] w_rd_val;

  always_comb begin
    w_lvl_sat = (int'(w_level) > 15) ? 4'hF : 4'(w_level);
    w_status                          = '0;
    w_status[c_STAT_EMPTY]            = w_empty;
    w_status[c_STAT_FULL]             = w_full;
    w_status[c_STAT_OVF]              = r_ovf;
    w_status[c_STAT_UDF]              = r_udf;
    w_status[c_STAT_LVL_LSB +: 4]     = w_lvl_sat;

    w_rd_val = '0;
    case (r_addr)
      c_ADDR_CTRL:  w_rd_val = DATA_W'(r_ctrl);
      c_ADDR_STAT:  w_rd_val = DATA_W'(w_status);
      c_ADDR_FIFO:  w_rd_val = w_empty ? '0 : w_fifo_head;
      c_ADDR_WMARK: w_rd_val = DATA_W'(r_wmark);
      c_ADDR_SIMD:  w_rd_val = simd_in;
      default:      w_rd_val = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file, stickies and read capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_ctrl      <= '0;
      r_wmark     <= wmark_default(FIFO_DEPTH);
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_pop_pend  <= 1'b0;
      r_simd_data <= '0;
      r_data_out  <= '0;
    end else begin
      if (w_addr_wr) begin
        r_addr <= pico_data_in[7:0];
      end else if (c_AUTOINC && (w_data_wr || w_data_rd) && (r_addr != c_ADDR_FIFO)) begin
        r_addr <= r_addr + 8'd1;
      end

      if (w_data_wr) begin
        case (r_addr)
          c_ADDR_CTRL:  r_ctrl      <= pico_data_in[c_CTRL_W-1:0];
          c_ADDR_WMARK: r_wmark     <= pico_data_in[7:0];
          c_ADDR_SIMD:  r_simd_data <= pico_data_in;
          default:      ;
        endcase
      end

      // Write-one-to-clear first; a new error in the same cycle wins.
      if (w_data_wr && (r_addr == c_ADDR_STAT)) begin
        if (pico_data_in[c_STAT_OVF]) r_ovf <= 1'b0;
        if (pico_data_in[c_STAT_UDF]) r_udf <= 1'b0;
      end
      if (w_push && w_full && !w_pop_req) begin
        r_ovf <= 1'b1;
      end
      if (w_pop_req && w_empty) begin
        r_udf <= 1'b1;
      end

      // Address-cycle reads return the address register itself.
      if (w_rd_rise) begin
        r_data_out <= w_cd ? DATA_W'(r_addr) : w_rd_val;
        r_pop_pend <= !w_cd && (r_addr == c_ADDR_FIFO);
      end else if (w_rd_fall) begin
        r_pop_pend <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // LCD stream
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lcd_data  <= '0;
      r_lcd_valid <= 1'b0;
    end else begin
      r_lcd_valid <= 1'b0;
      if (r_ctrl[c_CTRL_LCD_SRC]) begin
        r_lcd_data  <= w_cam_pix;
        r_lcd_valid <= w_cam_vld;
      end else if (w_data_wr && (r_addr == c_ADDR_SIMD)) begin
        r_lcd_data  <= pico_data_in;
        r_lcd_valid <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pico_data_out = r_data_out;
  assign pico_data_oe  = w_rd && w_cs;
  assign LCD_data      = r_lcd_data;
  assign LCD_valid     = r_lcd_valid;
  assign simd_data     = r_simd_data;
  assign irq           = (int'(w_level) >= int'(r_wmark)) || r_ovf || r_udf;

endmodule

`default_nettype wire

// File: tb/tb_pico_bus_router.sv
// ============================================================================
// Module      : tb_pico_bus_router
// Description : Scoreboard bench for pico_bus_router. Bus and camera tasks
//               update a queue-based reference model and push expected read
//               and LCD values; a monitor compares them as the DUT presents
//               them. Honours PICO_BUS_AUTOINC_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pico_bus_router;

  localparam int DATA_W     = 8;
  localparam int N_CAM      = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int SYNC       = 2;

  logic                    clk;
  logic                    rst;
  logic                    CS, WR, RD, CD;
  logic [DATA_W-1:0]       pico_data_in;
  logic [DATA_W-1:0]       pico_data_out;
  logic                    pico_data_oe;
  logic [N_CAM*DATA_W-1:0] cam_data;
  logic [N_CAM-1:0]        cam_valid;
  logic [DATA_W-1:0]       LCD_data;
  logic                    LCD_valid;
  logic [DATA_W-1:0]       simd_in;
  logic [DATA_W-1:0]       simd_data;
  logic                    irq;

  pico_bus_router #(
    .DATA_W      (DATA_W),
    .N_CAM       (N_CAM),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .CS            (CS),
    .WR            (WR),
    .RD            (RD),
    .CD            (CD),
    .pico_data_in  (pico_data_in),
    .pico_data_out (pico_data_out),
    .pico_data_oe  (pico_data_oe),
    .cam_data      (cam_data),
    .cam_valid     (cam_valid),
    .LCD_data      (LCD_data),
    .LCD_valid     (LCD_valid),
    .simd_in       (simd_in),
    .simd_data     (simd_data),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [7:0] m_addr, m_wmark, m_simd;
  logic [3:0] m_ctrl;
  bit         m_ovf, m_udf;
  logic [7:0] m_fifo[$];
  logic [7:0] rd_q[$];
  logic [7:0] lcd_q[$];

  task automatic model_reset();
    m_addr  = 8'h00;
    m_ctrl  = 4'h0;
    m_wmark = 8'(FIFO_DEPTH / 2);
    m_simd  = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_fifo.delete();
    rd_q.delete();
    lcd_q.delete();
  endtask

  function automatic int eff_sel();
    int s;
    s = int'(m_ctrl[2:1]);
    return (s >= N_CAM) ? 0 : s;
  endfunction

  function automatic logic [7:0] model_status();
    int lvl;
    logic [7:0] st;
    lvl = (m_fifo.size() > 15) ? 15 : m_fifo.size();
    st = 8'(lvl) << 4;
    if (m_fifo.size() == 0)          st = st | 8'h01;
    if (m_fifo.size() == FIFO_DEPTH) st = st | 8'h02;
    if (m_ovf)                       st = st | 8'h04;
    if (m_udf)                       st = st | 8'h08;
    return st;
  endfunction

  function automatic logic model_irq();
    return (m_fifo.size() >= int'(m_wmark)) || m_ovf || m_udf;
  endfunction

  function automatic logic [7:0] model_read();
    case (m_addr)
      8'h00:   return {4'h0, m_ctrl};
      8'h01:   return model_status();
      8'h02:   return (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
      8'h03:   return m_wmark;
      8'h04:   return simd_in;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_autoinc();
`ifdef PICO_BUS_AUTOINC_EN
    if (m_addr != 8'h02) m_addr = m_addr + 8'd1;
`endif
  endtask

  task automatic cam_model(input logic [N_CAM-1:0] v, input logic [N_CAM*DATA_W-1:0] d);
    int s;
    logic [7:0] pix;
    s = eff_sel();
    if (v[s]) begin
      pix = d[s*DATA_W +: DATA_W];
      if (m_ctrl[0]) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(pix);
        else m_ovf = 1'b1;
      end
      if (m_ctrl[3]) lcd_q.push_back(pix);
    end
  endtask

  task automatic model_pop();
    if (m_addr == 8'h02) begin
      if (m_fifo.size() > 0) void'(m_fifo.pop_front());
      else m_udf = 1'b1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus tasks (entered and left at posedge + 1)
  // --------------------------------------------------------------------------
  task automatic bus_write(input logic cd, input logic [7:0] d);
    // Model first so LCD expectations exist before the DUT produces them.
    if (cd) begin
      m_addr = d;
    end else begin
      case (m_addr)
        8'h00: m_ctrl = d[3:0];
        8'h01: begin
          if (d[2]) m_ovf = 1'b0;
          if (d[3]) m_udf = 1'b0;
        end
        8'h03: m_wmark = d;
        8'h04: begin
          m_simd = d;
          if (!m_ctrl[3]) lcd_q.push_back(d);
        end
        default: ;
      endcase
      model_autoinc();
    end
    CS = 1'b1; CD = cd; pico_data_in = d;
    @(posedge clk); #1; WR = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1; WR = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1; CS = 1'b0;
    @(posedge clk); #1;
    check("irq_after_wr", irq, model_irq());
    check("simd_data", simd_data, m_simd);
  endtask

  // push_en: drive a selected-channel pixel so that its push coincides with
  // the pop caused by the RD falling edge.
  task automatic bus_read_x(input bit push_en, input logic [7:0] pix);
    logic [N_CAM*DATA_W-1:0] d;
    CS = 1'b1; CD = 1'b0;
    rd_q.push_back(model_read());
    @(posedge clk); #1; RD = 1'b1;
    repeat (SYNC + 3) @(posedge clk);
    #1; RD = 1'b0;
    model_pop();
    model_autoinc();
    repeat (SYNC) @(posedge clk);
    #1;
    if (push_en) begin
      d = '0;
      d[1*DATA_W +: DATA_W] = pix;
      cam_data = d; cam_valid = 2'b10;
      cam_model(2'b10, d);
    end
    @(posedge clk); #1; cam_valid = '0;
    @(posedge clk); #1; CS = 1'b0;
    @(posedge clk); #1;
    check("irq_after_rd", irq, model_irq());
  endtask

  task automatic bus_read();
    bus_read_x(1'b0, 8'h00);
  endtask

  task automatic drive_cam(input logic [N_CAM-1:0] v, input logic [N_CAM*DATA_W-1:0] d);
    cam_valid = v; cam_data = d;
    cam_model(v, d);
    @(posedge clk); #1; cam_valid = '0;
    check("irq_after_cap", irq, model_irq());
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    CS = 1'b0; WR = 1'b0; RD = 1'b0; CD = 1'b0;
    cam_valid = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // --------------------------------------------------------------------------
  // Monitor: read data once oe has been high for two samples, LCD on valid
  // --------------------------------------------------------------------------
  int oe_cnt = 0;
  always @(negedge clk) begin
    if (pico_data_oe) begin
      oe_cnt++;
      if (oe_cnt == 2) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", pico_data_out);
        end else begin
          check("rd_data", pico_data_out, rd_q.pop_front());
        end
      end
    end else begin
      oe_cnt = 0;
    end
    if (LCD_valid) begin
      if (lcd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL lcd_unexpected: got 0x%0h expected no pulse", LCD_data);
      end else begin
        check("lcd_data", LCD_data, lcd_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    n_vec++; n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    bit seen;
    rst = 1'b0; CS = 1'b0; WR = 1'b0; RD = 1'b0; CD = 1'b0;
    pico_data_in = '0; cam_data = '0; cam_valid = '0; simd_in = 8'h5A;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_oe",      pico_data_oe,  1'b0);
    check("rst_rdata",   pico_data_out, 8'h00);
    check("rst_lcd_v",   LCD_valid,     1'b0);
    check("rst_lcd_d",   LCD_data,      8'h00);
    check("rst_simd",    simd_data,     8'h00);
    check("rst_irq",     irq,           1'b0);
    apply_reset();

    // CTRL write/read back: cap_en=1, cam_sel=1
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h03);
    bus_write(1'b1, 8'h00);
    bus_read();

    // Fill to full on channel 1, then overflow
    for (int i = 0; i < 16; i++)
      drive_cam({1'b1, 1'($urandom)}, {8'(8'h10 + i), 8'($urandom)});
    drive_cam(2'b10, {8'h20, 8'h00});
    bus_write(1'b1, 8'h01);
    bus_read();                       // STATUS 0xF6
    bus_write(1'b1, 8'h02);
    for (int i = 0; i < 17; i++) bus_read();  // 0x10..0x1F then 0
    bus_write(1'b1, 8'h01);
    bus_read();                       // empty + ovf + udf

    // Watermark and sticky clear
    bus_write(1'b1, 8'h03);
    bus_write(1'b0, 8'h04);
    bus_write(1'b1, 8'h01);
    bus_write(1'b0, 8'h0C);
    for (int i = 0; i < 4; i++) drive_cam(2'b10, {8'(8'hA0 + i), 8'h00});

    // Randomised traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 8))
        0, 1: drive_cam(2'($urandom), 16'($urandom));
        2: begin bus_write(1'b1, 8'h00); bus_write(1'b0, 8'($urandom_range(0, 15))); end
        3: begin bus_write(1'b1, 8'h03); bus_write(1'b0, 8'($urandom_range(0, 20))); bus_read(); end
        4: begin bus_write(1'b1, 8'h01); bus_read(); end
        5: begin bus_write(1'b1, 8'h02); bus_read(); end
        6: begin bus_write(1'b1, 8'h04); bus_write(1'b0, 8'($urandom)); end
        7: begin simd_in = 8'($urandom); bus_write(1'b1, 8'h04); bus_read(); end
        default: begin bus_write(1'b1, 8'h01); bus_write(1'b0, 8'($urandom)); end
      endcase
    end

    // Simultaneous push and pop at level 16
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h03);
    bus_write(1'b1, 8'h01);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b1, 8'h02);
    while (m_fifo.size() > 0) bus_read();
    while (m_fifo.size() < FIFO_DEPTH) drive_cam(2'b10, {8'($urandom), 8'h00});
    bus_read_x(1'b1, 8'hC7);
    bus_write(1'b1, 8'h01);
    bus_read();                       // full, level 15 sat, no overflow

    // Two data writes after one address cycle
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h05);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b1, 8'h00);
    bus_read();

    // Reset in the middle of a FIFO read
    bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h01);
    drive_cam(2'b01, {8'h00, 8'h33});
    drive_cam(2'b01, {8'h00, 8'h34});
    bus_write(1'b1, 8'h02);
    CS = 1'b1; CD = 1'b0;
    @(posedge clk); #1; RD = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (pico_data_oe) seen = 1'b1;
    end
    check("oe_before_rst", seen, 1'b1);
    rst = 1'b0;
    #1;
    check("oe_in_rst", pico_data_oe, 1'b0);
    check("rdata_in_rst", pico_data_out, 8'h00);
    RD = 1'b0; CS = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    bus_write(1'b1, 8'h01);
    bus_read();                       // STATUS 0x01
    bus_write(1'b1, 8'h00);
    bus_read();                       // CTRL 0

    repeat (10) @(posedge clk);
    #1;
    check("rd_q_left",  rd_q.size(),  0);
    check("lcd_q_left", lcd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
